// File: rtl/sar_search_controller_pkg.sv
// Shared types for the SAR search controller: state encoding, flag decode, defaults.
// Combinational helpers only; no latency or backpressure.
package sar_search_controller_pkg;

  localparam int DEFAULT_WIDTH         = 8;
  localparam int DEFAULT_SETTLE_CYCLES = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PROBE  = 2'd1,
    S_VERIFY = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FLAG_EQ  = 2'd0,
    FLAG_LT  = 2'd1,
    FLAG_GT  = 2'd2,
    FLAG_BAD = 2'd3
  } flag_t;

  // Exactly one comparator flag must be set; anything else is a fault.
  function automatic flag_t decode_flags(input logic eq, input logic lt, input logic gt);
    flag_t f;
    case ({eq, lt, gt})
      3'b100:  f = FLAG_EQ;
      3'b010:  f = FLAG_LT;
      3'b001:  f = FLAG_GT;
      default: f = FLAG_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sar_search_controller_if.sv
// Start/done handshake, comparator flags and probe/result bus of the SAR controller.
// Wires only; the controller never stalls, start is simply ignored while busy.
interface sar_search_controller_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             cmp_equal;
  logic             cmp_lower;
  logic             cmp_greater;
  logic [WIDTH-1:0] probe;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             error;

  modport master (
    input  start, cmp_equal, cmp_lower, cmp_greater,
    output probe, busy, done, result, found, error
  );

  modport slave (
    output start, cmp_equal, cmp_lower, cmp_greater,
    input  probe, busy, done, result, found, error
  );
endinterface

// File: rtl/sar_settle_timer.sv
// Loadable down-counter; sample strobes once SETTLE_CYCLES enabled cycles follow a load.
// Latency SETTLE_CYCLES+1 enabled cycles from load to sample; no backpressure.
module sar_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic sample
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= 4'(SETTLE_CYCLES);
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign sample = en && (count == 4'd0);

endmodule

// File: rtl/sar_search_controller.sv
// Binary-search an external comparator's a input by driving its b probe, one bit per step.
// Latency up to (WIDTH+1)*(SETTLE_CYCLES+1)+1 cycles; start ignored while a search is running.
module sar_search_controller
  import sar_search_controller_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  sar_search_controller_if.master bus
);

  localparam int              IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] probe_q, probe_n;
  logic [WIDTH-1:0] result_q, result_n;
  logic [IW-1:0]    idx_q, idx_n, idx_dec;
  logic             found_q, found_n;
  logic             error_q, error_n;
  logic             tmr_load, tmr_en, sample;
  logic [WIDTH-1:0] kept;
  flag_t            flag;

  sar_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .en     (tmr_en),
    .sample (sample)
  );

  assign flag    = decode_flags(bus.cmp_equal, bus.cmp_lower, bus.cmp_greater);
  assign idx_dec = idx_q - IW'(1);
  // A greater decision keeps the trial bit, which is already set in the probe.
  assign kept    = (flag == FLAG_GT) ? probe_q : result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      probe_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_n;
      probe_q  <= probe_n;
      result_q <= result_n;
      idx_q    <= idx_n;
      found_q  <= found_n;
      error_q  <= error_n;
    end
  end

  always_comb begin
    state_n  = state;
    probe_n  = probe_q;
    result_n = result_q;
    idx_n    = idx_q;
    found_n  = found_q;
    error_n  = error_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          result_n = '0;
          found_n  = 1'b0;
          error_n  = 1'b0;
          probe_n  = ONE << (WIDTH - 1);
          idx_n    = IW'(WIDTH - 1);
          tmr_load = 1'b1;
          state_n  = S_PROBE;
        end
      end

      S_PROBE: begin
        tmr_en = 1'b1;
        if (sample) begin
          case (flag)
            FLAG_EQ: begin
              result_n = probe_q;
              found_n  = 1'b1;
              state_n  = S_FINISH;
            end
            FLAG_LT, FLAG_GT: begin
              result_n = kept;
              tmr_load = 1'b1;
              if (idx_q != '0) begin
                idx_n   = idx_dec;
                probe_n = kept | (ONE << idx_dec);
              end else begin
                probe_n = kept;
                state_n = S_VERIFY;
              end
            end
            default: begin
              error_n = 1'b1;
              found_n = 1'b0;
              state_n = S_FINISH;
            end
          endcase
        end
      end

      S_VERIFY: begin
        tmr_en = 1'b1;
        if (sample) begin
          found_n = (flag == FLAG_EQ);
          error_n = (flag == FLAG_BAD);
          state_n = S_FINISH;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.probe  = probe_q;
  assign bus.result = result_q;
  assign bus.found  = found_q;
  assign bus.error  = error_q;
  assign bus.busy   = (state == S_PROBE) || (state == S_VERIFY);
  assign bus.done   = (state == S_FINISH);

endmodule

// File: doc/sar_search_controller.md
Name: sar_search_controller

Overview:
- Sequential controller that drives the `b` probe input of an external 8-bit magnitude comparator and reads back its equal/lower/greater flags.
- Uses successive approximation (binary search) to recover the unknown value applied to the comparator's `a` input.
- Sits beside the comparator in the Spartan6 datapath and turns three static flags into a registered result with a start/done handshake.

Parameters:
- WIDTH, 8, bit width of probe and result; must match comparator width.
- SETTLE_CYCLES, 1, cycles a probe is held before the flags are sampled (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a search; ignored while busy=1.
- cmp_equal  input  1  comparator flag, a==probe.
- cmp_lower  input  1  comparator flag, a<probe.
- cmp_greater  input  1  comparator flag, a>probe.
- probe  output  WIDTH  registered value driven to the comparator b input.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when result, found and error are valid.
- result  output  WIDTH  recovered value; held until the next accepted start.
- found  output  1  equality with result was confirmed by the comparator.
- error  output  1  an illegal flag combination was sampled.

Interface decision: one clock (clk); reset is synchronous and active-high (reset).

Behaviour:
- **Reset:** probe=0, result=0, busy=0, done=0, found=0, error=0, state=IDLE. Reset mid-search aborts the search; no done pulse is produced.
- **States:** IDLE, PROBE, VERIFY, FINISH.
- **IDLE:**
  - On start=1: clear result, found and error; set probe=1<<(WIDTH-1), bit index=WIDTH-1, settle count=0, busy=1.
  - Go to PROBE.
- **PROBE:**
  - Hold probe and increment the settle count.
  - When the count reaches SETTLE_CYCLES, sample the flags that cycle:
    - Exactly cmp_equal: result=probe, found=1, go to FINISH (early exit).
    - Exactly cmp_greater: keep the bit in result (result=probe).
    - Exactly cmp_lower: clear the bit (result unchanged).
    - Any other combination (none set, or more than one set): error=1, found=0, go to FINISH.
  - After a greater/lower decision:
    - If bit index>0: decrement the index, set probe=result|(1<<new index), reset the settle count, stay in PROBE.
    - If bit index=0: set probe=result and go to VERIFY.
- **VERIFY:**
  - Same settle timing as PROBE.
  - On sample: found=cmp_equal. Illegal flags set error=1 and found=0.
  - Go to FINISH.
  - This covers a==0 and any value not hit by an equal during the search.
- **FINISH:**
  - done=1 for exactly one cycle, busy=0 at the same time, probe held.
  - Return to IDLE.
- **Timing:**
  - Each probe step takes SETTLE_CYCLES+1 cycles.
  - Worst-case latency from start to done is (WIDTH+1)*(SETTLE_CYCLES+1)+1 cycles.
  - Early exit at step k (1-based) gives done at k*(SETTLE_CYCLES+1)+1 cycles after start.
- **Simultaneous events:** start coinciding with done/FINISH is ignored; reset has priority over start.
- **Arithmetic:** all probe/result values are unsigned WIDTH-bit; no carries are generated (bit-set/clear only).

Decomposition:
- **Shared package:**
  - State encoding localparams (IDLE/PROBE/VERIFY/FINISH).
  - Flag-decode codes (FLAG_EQ, FLAG_LT, FLAG_GT, FLAG_BAD).
  - Default WIDTH and SETTLE_CYCLES.
- **One sub-module: sar_settle_timer.**
  - Loadable down-counter with a `sample` strobe output.
  - Reused by the PROBE and VERIFY states.

Test Plan:
1. a=0xA5, SETTLE_CYCLES=1, start pulse -> probes 80,C0,A0,B0,A8,A4,A6,A5, each held 2 cycles; equal on A5 -> done pulse with result=0xA5, found=1, error=0, busy low in the done cycle.
2. a=0x80 -> first probe 0x80 is equal -> done 3 cycles after start, result=0x80, found=1; no further probes issued.
3. a=0x00 -> probes 80,40,20,10,08,04,02,01 all lower, then VERIFY probe 00 equal -> result=0x00, found=1, done 19 cycles after start.
4. a=0xFF -> probes 80,C0,E0,F0,F8,FC,FE,FF, greater until FF equal -> result=0xFF, found=1; a second start pulsed mid-search is ignored (only one done).
5. Bench forces cmp_lower=cmp_greater=1 on the first sample -> error=1, found=0, done pulse; the next start with legal flags clears error.
6. Reset asserted 5 cycles into a search for 0x3C -> next cycle probe=0, busy=0, no done pulse; a fresh start then completes with result=0x3C, found=1.
